// File: rtl/usrt_tx.sv
// usrt_tx: synchronous serial transmitter driving a gated serial clock
// (usrt_clk) and serial data (usrt_data) from parallel words accepted over a
// valid/ready handshake.
//
// Frame: start bit (0), DATA_BITS data bits LSB first, optional even parity
// bit, stop bit (1). Each bit lasts 2*HALF_PERIOD clk cycles. usrt_clk rises
// halfway through each bit, which is where the receiver samples. usrt_clk
// falls at the end of the bit, and the data line moves to the next bit in
// that same cycle.
//
// Optional feature macro: USRT_TX_PARITY_EN. When it is defined, an even
// parity bit (XOR of the data bits) is sent between the MSB and the stop bit.
//
// Parameter limits: HALF_PERIOD >= 2, DATA_BITS >= 2.
// All outputs are registered. There is no combinational path from any input
// to any output.
module usrt_tx #(
   parameter int HALF_PERIOD = 8,
   parameter int DATA_BITS   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 usrt_clk,
   output logic                 usrt_data,
   output logic                 tx_busy
);

   localparam int HC_W = $clog2(HALF_PERIOD);
   localparam int BC_W = $clog2(DATA_BITS);
   localparam logic [HC_W-1:0] HC_LAST = HC_W'(HALF_PERIOD - 1);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

`ifdef USRT_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t                state;
   logic [HC_W-1:0]       hc;        // clk cycles within the current half-period
   logic [BC_W-1:0]       bit_cnt;   // index of the data bit on the line
   logic [DATA_BITS-1:0]  shreg;     // bit 0 is the data bit currently on the line
`ifdef USRT_TX_PARITY_EN
   logic                  parity;    // even parity of the accepted word
`endif

   // Frame sequencer. While a frame runs, usrt_clk itself records which
   // half of the bit is in progress: low means the first half, high means
   // the second half.
   // NOTE: every register in this block is assigned with <= so that all
   // next-state values are computed from the values held before the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         hc        <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
`ifdef USRT_TX_PARITY_EN
         parity    <= 1'b0;
`endif
         tx_ready  <= 1'b1;
         tx_busy   <= 1'b0;
         usrt_clk  <= 1'b0;
         usrt_data <= 1'b1;
      end else if (state == IDLE) begin
         // tx_ready is always high in IDLE, so tx_valid alone marks an accept.
         if (tx_valid) begin
            shreg     <= tx_data;
`ifdef USRT_TX_PARITY_EN
            parity    <= ^tx_data;
`endif
            hc        <= '0;
            bit_cnt   <= '0;
            state     <= START;
            usrt_data <= 1'b0;
            tx_ready  <= 1'b0;
            tx_busy   <= 1'b1;
         end
      end else if (hc != HC_LAST) begin
         hc <= hc + 1'b1;
      end else begin
         hc <= '0;
         if (!usrt_clk) begin
            // End of the first half: the receiver samples on this rising edge.
            usrt_clk <= 1'b1;
         end else begin
            // End of the bit: falling edge, and the data line advances.
            usrt_clk <= 1'b0;
            case (state)
               START: begin
                  state     <= DATA;
                  usrt_data <= shreg[0];
               end
               DATA: begin
                  if (bit_cnt == BC_LAST) begin
`ifdef USRT_TX_PARITY_EN
                     state     <= PARITY;
                     usrt_data <= parity;
`else
                     state     <= STOP;
                     usrt_data <= 1'b1;
`endif
                  end else begin
                     bit_cnt   <= bit_cnt + 1'b1;
                     shreg     <= shreg >> 1;
                     usrt_data <= shreg[1];
                  end
               end
`ifdef USRT_TX_PARITY_EN
               PARITY: begin
                  state     <= STOP;
                  usrt_data <= 1'b1;
               end
`endif
               STOP: begin
                  state     <= IDLE;
                  usrt_data <= 1'b1;
                  tx_ready  <= 1'b1;
                  tx_busy   <= 1'b0;
               end
               default: begin
                  state     <= IDLE;
                  usrt_data <= 1'b1;
                  tx_ready  <= 1'b1;
                  tx_busy   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/usrt_tx.md
# usrt_tx

Synchronous serial transmitter that drives both the serial clock and the serial data line of the USRT link. It is the transmitting end of the interface whose receiver detects `usrt_clk` rising edges in the `clk` domain and samples data there. It accepts parallel words over a valid/ready handshake and emits one framed word per transfer, generating a gated `usrt_clk` burst derived from `clk`.

## Interface
- `HALF_PERIOD`, default 8: `clk` cycles per `usrt_clk` half-period; legal values ≥ 2.
- `DATA_BITS`, default 8: payload width.

- `clk`  in  1: system clock; all logic is rising-edge.
- `rst`  in  1: reset; synchronous and active-high.
- `tx_data`  in  DATA_BITS: word to send; sampled on accept.
- `tx_valid`  in  1: `tx_data` is valid.
- `tx_ready`  out  1: transmitter can accept a word.
- `usrt_clk`  out  1: serial clock; idles low, toggles only during a frame.
- `usrt_data`  out  1: serial data; idles high.
- `tx_busy`  out  1: frame in progress (equals `~tx_ready`).

## Operation
- Frame order:
  - start bit (0);
  - `DATA_BITS` data bits, LSB first;
  - parity bit, only when configured;
  - stop bit (1).
- Bits per frame: N = DATA_BITS + 2, plus 1 with parity.
- FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE.
- IDLE:
  - `tx_ready`=1, `usrt_clk`=0, `usrt_data`=1.
  - Accept occurs when `tx_valid && tx_ready` at a rising edge of `clk`. The word is latched into the shift register, the half-period counter clears, and the FSM moves to START.
- Per bit, with counter `hc` running 0..HALF_PERIOD-1 (width `$clog2(HALF_PERIOD)`):
  - `usrt_data` is stable for the whole bit.
  - When `hc` wraps at the end of the first half, `usrt_clk` rises. The receiver samples on this edge.
  - When `hc` wraps at the end of the second half, `usrt_clk` falls. In the same cycle, `usrt_data` moves to the next bit.
- DATA uses a bit counter 0..DATA_BITS-1. The shift register shifts right on each falling edge.
- STOP: at the stop bit's falling edge, the FSM enters IDLE and `usrt_clk` stays low.
- `tx_valid` is ignored outside IDLE. `tx_data` may change freely once accepted.
- Reset:
  - While `rst` is high, every output takes its idle value at the next `clk` edge. This holds mid-frame too: the frame is abandoned and no further edges are emitted.
  - `tx_valid` is ignored while `rst` is high.
- Reset values: `tx_ready`=1, `tx_busy`=0, `usrt_clk`=0, `usrt_data`=1; FSM in IDLE, counters 0.

## Timing
- Accept edge at cycle 0. From cycle 1, `usrt_data`=0 (start bit), `tx_ready`=0, `tx_busy`=1.
- For bit k (k=0..N-1), `usrt_clk` rises at cycle 1 + 2k·HALF_PERIOD + HALF_PERIOD and falls at cycle 1 + 2(k+1)·HALF_PERIOD.
- `tx_ready` returns to 1 at cycle 1 + 2N·HALF_PERIOD, the same cycle as the final falling edge.
- Back-to-back frames:
  - A word accepted in that cycle starts its start bit on the next cycle.
  - Inter-frame gap is 1 cycle with `usrt_clk` low and `usrt_data`=1.
- Serial bit rate = f_clk / (2·HALF_PERIOD).
- No combinational path from inputs to outputs; all outputs are registered.

## Configuration
- `USRT_TX_PARITY_EN`:
  - Defined: an even parity bit (XOR of all data bits) is sent between the MSB and the stop bit, the PARITY state exists, and N = DATA_BITS + 3.
  - Undefined: no PARITY state, N = DATA_BITS + 2, and the FSM goes DATA → STOP directly.

## Test plan
- Reset idle: hold `rst` for 3 cycles, then release with `tx_valid`=0 → `tx_ready`=1, `usrt_clk`=0, `usrt_data`=1 for 50 cycles, no edges.
- Single word, no parity: HALF_PERIOD=8, send 0xA5.
  - Values sampled on 10 `usrt_clk` rising edges are 0,1,0,1,0,0,1,0,1,1.
  - First rise at cycle 9.
  - `tx_ready` returns at cycle 161.
- Parity: with `USRT_TX_PARITY_EN` defined, send 0xA5, then 0x07.
  - 0xA5: 11 sampled bits, parity bit 0, ready at cycle 177.
  - 0x07: parity bit 1.
- Back-to-back: hold `tx_valid`=1 with words 0x00 then 0xFF → second start bit begins exactly 1 cycle after the first frame's last falling edge; no word is lost or duplicated.
- Busy ignore: pulse `tx_valid` with 0x3C mid-frame of 0x55 → only 0x55 is transmitted and 0x3C is not accepted.
- Reset mid-frame: assert `rst` for 1 cycle during data bit 3 → next cycle shows idle outputs, no further `usrt_clk` edges, and a fresh word is then sent correctly.
